divider_8bit_ctrl: RTL
======================

Name: divider_8bit_ctrl

Overview:
Handshake front-end and result collector for the 8-bit array divider. It accepts unsigned 8-bit operand pairs on a valid/ready interface and drives the divider's load strobe and operand inputs. It waits a fixed settle time for the combinational array, then captures quotient and remainder into output registers and holds them until the consumer accepts. Divide-by-zero is resolved locally without using the array.

Parameters:
SETTLE_CYCLES, 2, cycles allowed for the array to settle after the divider's input registers load; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept an operand pair
in_dividend  input  8  unsigned dividend
in_divisor  input  8  unsigned divisor
div_load  output  1  one-cycle load strobe to the divider's input registers (wired to the divider's rst)
div_dividend  output  8  registered dividend to the divider
div_divisor  output  8  registered divisor to the divider
div_quotient  input  9  divider quotient; bit 8 must be 0 for a nonzero divisor
div_remainder  input  9  divider corrected remainder; bit 8 must be 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_quotient  output  8  captured quotient
out_remainder  output  8  captured remainder
out_dbz  output  1  result came from a divide-by-zero
out_err  output  1  divider returned nonzero bit 8 on quotient or remainder

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state IDLE, in_ready=1, div_load=0, div_dividend=0, div_divisor=0, out_valid=0, out_quotient=0, out_remainder=0, out_dbz=0, out_err=0, settle counter=0.
- An operand pair is accepted when in_valid and in_ready are both high on a rising edge. The operands are latched into div_dividend and div_divisor.
- FSM states: IDLE, LOAD, SETTLE, DONE.
- IDLE: in_ready=1.
  - On accept with divisor≠0: go to LOAD.
  - On accept with divisor=0: go straight to DONE with out_quotient=8'hFF, out_remainder=in_dividend, out_dbz=1, out_err=0.
- LOAD: div_load=1 for exactly this cycle. Clear the counter. Go to SETTLE.
- SETTLE: increment the counter each cycle. In the cycle where counter==SETTLE_CYCLES-1, capture the results and go to DONE:
  - out_quotient=div_quotient[7:0]
  - out_remainder=div_remainder[7:0]
  - out_err=div_quotient[8]|div_remainder[8]
  - out_dbz=0
- DONE: out_valid=1 and all out_* are held stable. Go to IDLE on out_ready, and out_valid falls on that edge.
- in_ready is low in LOAD, SETTLE and DONE. in_valid during those states is ignored and the operands are not consumed.
- Latency: accept edge at cycle T → out_valid high from cycle T+2+SETTLE_CYCLES (normal path), or from T+1 (divide-by-zero).
- Throughput: a new accept is possible in the cycle after out_ready is taken.
- div_dividend and div_divisor change only on accept and stay constant through LOAD, SETTLE and DONE.
- div_load is never asserted outside LOAD, and never for two consecutive cycles.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation (any state): return to reset values on the next edge, the pending result is discarded, and div_load is deasserted. A reset in LOAD takes priority over the strobe.
- No arithmetic is done in this block beyond the divide-by-zero override. Results are the unsigned quotient and remainder.

Test Plan:
- 200/7, SETTLE_CYCLES=2, out_ready=1 → div_load pulses once at T+1; out_valid at T+4; quotient=28 (0x1C), remainder=4, dbz=0, err=0.
- 13/0 → out_valid at T+1, quotient=0xFF, remainder=13, dbz=1; div_load never asserted.
- 255/1, then 5/9, and 0/3 back-to-back with in_valid held high → each accepted only in IDLE; results (255,0), (0,5), (0,0) delivered in order with no duplicates.
- Backpressure: 100/10 with out_ready low for 6 cycles → out_valid and quotient=10, remainder=0 held stable; in_ready stays low; a second request is accepted the cycle after out_ready rises.
- Reset asserted during SETTLE for 50/3 → next cycle all outputs at reset values, in_ready=1; a following 9/2 completes with quotient=4, remainder=1.
- Divider model forced to return div_quotient[8]=1 for 40/5 → out_err=1 and out_quotient=div_quotient[7:0], out_valid handshake unchanged.

Source files
------------

// File: rtl/divider_8bit_ctrl.sv
// Valid/ready front-end for the 8-bit array divider: loads operands, waits out the array settle time, holds the result.
// Latency: accept at T -> out_valid from T+2+SETTLE_CYCLES (T+1 for divide-by-zero); holds while out_ready is low.
module divider_8bit_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_dividend,
    input  logic [7:0] in_divisor,
    output logic       div_load,
    output logic [7:0] div_dividend,
    output logic [7:0] div_divisor,
    input  logic [8:0] div_quotient,
    input  logic [8:0] div_remainder,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_quotient,
    output logic [7:0] out_remainder,
    output logic       out_dbz,
    output logic       out_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] dividend_q, dividend_d;
    logic [7:0] divisor_q, divisor_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
    logic       err_q, err_d;

    logic accept;
    logic capture;

    assign accept  = in_valid && (state_q == IDLE);
    assign capture = (state_q == SETTLE) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            dividend_q <= 8'd0;
            divisor_q  <= 8'd0;
            quo_q      <= 8'd0;
            rem_q      <= 8'd0;
            dbz_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (in_divisor == 8'd0) ? DONE : LOAD;
            LOAD:    state_d = SETTLE;
            SETTLE:  if (capture) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        div_load  = (state_q == LOAD);
        out_valid = (state_q == DONE);
    end

    // Divide-by-zero never touches the array: the result is forced here instead.
    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        err_d      = err_q;
        if (accept) begin
            dividend_d = in_dividend;
            divisor_d  = in_divisor;
            if (in_divisor == 8'd0) begin
                quo_d = 8'hFF;
                rem_d = in_dividend;
                dbz_d = 1'b1;
                err_d = 1'b0;
            end
        end
        if (state_q == LOAD)
            cnt_d = 4'd0;
        else if (state_q == SETTLE)
            cnt_d = cnt_q + 4'd1;
        if (capture) begin
            quo_d = div_quotient[7:0];
            rem_d = div_remainder[7:0];
            err_d = div_quotient[8] | div_remainder[8];
            dbz_d = 1'b0;
        end
    end

    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;
    assign out_dbz       = dbz_q;
    assign out_err       = err_q;

endmodule
